race_controller: RTL and testbench

//  Central game sequencer for the two-player drag race, instantiated in top between the menu/UART link and the timers/draw chain.

---
 rtl/race_controller.sv | 192 +++++++++++++++++++
 tb/tb_race_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// Two-player drag race sequencer: start sync, light countdown, race timing,
// winner/result handling, restart pulse and a link watchdog toward the peer board.
module race_controller #(
    parameter logic [31:0] FINISH_LINE_POS = 32'd25000,
    parameter int          LIGHT_SECONDS   = 5,
    parameter int          LINK_TIMEOUT_MS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1khz,
    input  logic        start_req_p1,
    input  logic        start_req_p2,
    input  logic        ack_p1,
    input  logic        ack_p2,
    input  logic        rx_valid,
    input  logic [31:0] position_p1,
    input  logic [31:0] position_p2,
    output logic        game_active,
    output logic [2:0]  light_count,
    output logic        lights_done,
    output logic        race_en_p1,
    output logic        race_en_p2,
    output logic        finish_p1,
    output logic        finish_p2,
    output logic [1:0]  winner,
    output logic [21:0] time_p1,
    output logic [21:0] time_p2,
    output logic        end_game,
    output logic        restart_tick,
    output logic        link_lost
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        LIGHTS  = 3'd2,
        RACE    = 3'd3,
        RESULT  = 3'd4,
        RESTART = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  ms_q, ms_d;
    logic [15:0] wd_q, wd_d;
    logic [2:0]  light_d;
    logic        fin1_d, fin2_d, lost_d;
    logic [1:0]  win_d;
    logic [21:0] t1_d, t2_d;
    logic        hit1, hit2, watch;

    // Race time is {seconds, ms}; once at 4095.999 it stays there.
    function automatic logic [21:0] time_inc(input logic [21:0] t);
        logic [21:0] r;
        r = t;
        if (t[9:0] == 10'd999) begin
            if (t[21:10] != 12'hFFF)
                r = {t[21:10] + 12'd1, 10'd0};
        end else begin
            r = {t[21:10], t[9:0] + 10'd1};
        end
        return r;
    endfunction

    assign hit1  = !finish_p1 && (position_p1 >= FINISH_LINE_POS);
    assign hit2  = !finish_p2 && (position_p2 >= FINISH_LINE_POS);
    assign watch = (state_q == SYNC) || (state_q == LIGHTS) ||
                   (state_q == RACE) || (state_q == RESULT);

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        light_d = light_count;
        fin1_d  = finish_p1;
        fin2_d  = finish_p2;
        win_d   = winner;
        t1_d    = time_p1;
        t2_d    = time_p2;
        lost_d  = link_lost;
        wd_d    = '0;

        if (watch) begin
            if (rx_valid)
                wd_d = '0;
            else if (tick_1khz)
                wd_d = wd_q + 16'd1;
            else
                wd_d = wd_q;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid)
                    lost_d = 1'b0;
                if (start_req_p1 && start_req_p2)
                    state_d = LIGHTS;
                else if (start_req_p1)
                    state_d = SYNC;
            end
            SYNC: begin
                if (!start_req_p1)
                    state_d = IDLE;
                else if (start_req_p2)
                    state_d = LIGHTS;
            end
            LIGHTS: begin
                if (tick_1khz) begin
                    if (ms_q == 10'd999) begin
                        ms_d    = '0;
                        light_d = light_count + 3'd1;
                        if (light_d == 3'(LIGHT_SECONDS))
                            state_d = RACE;
                    end else begin
                        ms_d = ms_q + 10'd1;
                    end
                end
            end
            RACE: begin
                if (tick_1khz) begin
                    if (!finish_p1) t1_d = time_inc(time_p1);
                    if (!finish_p2) t2_d = time_inc(time_p2);
                end
                fin1_d = finish_p1 | hit1;
                fin2_d = finish_p2 | hit2;
                if (winner == 2'b00 && (hit1 || hit2))
                    win_d = {hit2, hit1};
                if (fin1_d && fin2_d)
                    state_d = RESULT;
            end
            RESULT: begin
                if (ack_p1 && ack_p2)
                    state_d = RESTART;
            end
            RESTART: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A silent peer aborts whatever transition was chosen above.
        if (watch && wd_d == 16'(LINK_TIMEOUT_MS)) begin
            lost_d  = 1'b1;
            state_d = RESTART;
        end

        if (state_d == RESTART) begin
            ms_d    = '0;
            light_d = '0;
            fin1_d  = 1'b0;
            fin2_d  = 1'b0;
            win_d   = '0;
            t1_d    = '0;
            t2_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ms_q         <= '0;
            wd_q         <= '0;
            light_count  <= '0;
            finish_p1    <= 1'b0;
            finish_p2    <= 1'b0;
            winner       <= '0;
            time_p1      <= '0;
            time_p2      <= '0;
            link_lost    <= 1'b0;
            game_active  <= 1'b0;
            lights_done  <= 1'b0;
            race_en_p1   <= 1'b0;
            race_en_p2   <= 1'b0;
            end_game     <= 1'b0;
            restart_tick <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_q         <= ms_d;
            wd_q         <= wd_d;
            light_count  <= light_d;
            finish_p1    <= fin1_d;
            finish_p2    <= fin2_d;
            winner       <= win_d;
            time_p1      <= t1_d;
            time_p2      <= t2_d;
            link_lost    <= lost_d;
            game_active  <= !(state_d == IDLE || state_d == SYNC);
            lights_done  <= (state_d == RACE) || (state_d == RESULT);
            race_en_p1   <= (state_d == RACE) && !fin1_d;
            race_en_p2   <= (state_d == RACE) && !fin2_d;
            end_game     <= (state_d == RESULT);
            restart_tick <= (state_d == RESTART);
        end
    end

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_race_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1khz = 1'b0, start_req_p1 = 1'b0, start_req_p2 = 1'b0;
    logic        ack_p1 = 1'b0, ack_p2 = 1'b0, rx_valid = 1'b0;
    logic [31:0] position_p1 = '0, position_p2 = '0;
    logic        game_active, lights_done, race_en_p1, race_en_p2;
    logic        finish_p1, finish_p2, end_game, restart_tick, link_lost;
    logic [2:0]  light_count;
    logic [1:0]  winner;
    logic [21:0] time_p1, time_p2;

    race_controller #(
        .FINISH_LINE_POS(32'd25000), .LIGHT_SECONDS(5), .LINK_TIMEOUT_MS(500)
    ) dut (
        .clk(clk), .rst(rst), .tick_1khz(tick_1khz),
        .start_req_p1(start_req_p1), .start_req_p2(start_req_p2),
        .ack_p1(ack_p1), .ack_p2(ack_p2), .rx_valid(rx_valid),
        .position_p1(position_p1), .position_p2(position_p2),
        .game_active(game_active), .light_count(light_count), .lights_done(lights_done),
        .race_en_p1(race_en_p1), .race_en_p2(race_en_p2),
        .finish_p1(finish_p1), .finish_p2(finish_p2), .winner(winner),
        .time_p1(time_p1), .time_p2(time_p2), .end_game(end_game),
        .restart_tick(restart_tick), .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ga;
        logic [2:0]  lc;
        logic        ld;
        logic        re1, re2, f1, f2;
        logic [1:0]  win;
        logic [21:0] t1, t2;
        logic        eg, rt, ll;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } item_t;

    item_t q[$];
    int    tests = 0, fails = 0, rt_cnt = 0;
    logic  rx_on = 1'b1;
    obs_t  act;

    assign act = {game_active, light_count, lights_done, race_en_p1, race_en_p2,
                  finish_p1, finish_p2, winner, time_p1, time_p2,
                  end_game, restart_tick, link_lost};

    function automatic logic [21:0] tm(input int s, input int m);
        logic [11:0] sv;
        logic [9:0]  mv;
        sv = s[11:0];
        mv = m[9:0];
        return {sv, mv};
    endfunction

    function automatic obs_t mk(input logic ga, input logic [2:0] lc, input logic ld,
                                input logic re1, input logic re2, input logic f1, input logic f2,
                                input logic [1:0] w, input logic [21:0] t1, input logic [21:0] t2,
                                input logic eg, input logic rt, input logic ll);
        return {ga, lc, ld, re1, re2, f1, f2, w, t1, t2, eg, rt, ll};
    endfunction

    task automatic expect_obs(input string name, input obs_t e);
        item_t it;
        it.name = name;
        it.exp  = e;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            tests++;
            if (act !== it.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
        if (restart_tick) rt_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick pulse (with rx_valid alongside when rx_on) followed by an idle cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1khz = 1'b1;
            rx_valid  = rx_on;
            step();
            tick_1khz = 1'b0;
            rx_valid  = 1'b0;
            step();
        end
    endtask

    task automatic start_and_count();
        start_req_p1 = 1'b1;
        start_req_p2 = 1'b1;
        step();
        start_req_p1 = 1'b0;
        start_req_p2 = 1'b0;
        ticks(5000);
    endtask

    obs_t race0;

    initial begin
        race0 = mk(1, 3'd5, 1, 1, 1, 0, 0, 2'b00, '0, '0, 0, 0, 0);
        repeat (2) step();
        expect_obs("reset", '0);
        step();
        rst = 1'b0;
        step();
        expect_obs("idle_after_reset", '0);

        // Start sync and countdown
        start_req_p1 = 1'b1;
        step();
        expect_obs("sync_no_video", '0);
        start_req_p2 = 1'b1;
        step();
        expect_obs("lights_entry", mk(1, 3'd0, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 0, 0));
        for (int k = 1; k <= 4; k++) begin
            ticks(999);
            expect_obs("lights_before_sec", mk(1, 3'(k - 1), 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 0, 0));
            ticks(1);
            expect_obs("lights_sec_step", mk(1, 3'(k), 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 0, 0));
        end
        ticks(999);
        expect_obs("lights_last_sec", mk(1, 3'd4, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 0, 0));
        ticks(1);
        expect_obs("race_entry", race0);

        // Race: p1 finishes at 1.234 s, p2 at 2.000 s
        ticks(1234);
        position_p1 = 32'd24999;
        step();
        expect_obs("below_line", mk(1, 3'd5, 1, 1, 1, 0, 0, 2'b00, tm(1, 234), tm(1, 234), 0, 0, 0));
        position_p1 = 32'd25000;
        step();
        expect_obs("p1_finish", mk(1, 3'd5, 1, 0, 1, 1, 0, 2'b01, tm(1, 234), tm(1, 234), 0, 0, 0));
        ticks(766);
        expect_obs("p2_running", mk(1, 3'd5, 1, 0, 1, 1, 0, 2'b01, tm(1, 234), tm(2, 0), 0, 0, 0));
        position_p2 = 32'd25000;
        step();
        expect_obs("result_p1_wins", mk(1, 3'd5, 1, 0, 0, 1, 1, 2'b01, tm(1, 234), tm(2, 0), 1, 0, 0));
        ack_p1 = 1'b1;
        step();
        expect_obs("one_ack_holds", mk(1, 3'd5, 1, 0, 0, 1, 1, 2'b01, tm(1, 234), tm(2, 0), 1, 0, 0));
        ack_p2 = 1'b1;
        step();
        expect_obs("restart_pulse", mk(1, 3'd0, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 1, 0));
        ack_p1 = 1'b0; ack_p2 = 1'b0;
        start_req_p1 = 1'b0; start_req_p2 = 1'b0;
        position_p1 = '0; position_p2 = '0;
        step();
        expect_obs("restart_to_idle", '0);

        // Tie
        start_and_count();
        expect_obs("tie_race_entry", race0);
        ticks(3);
        position_p1 = 32'd30000;
        position_p2 = 32'hFFFF_FFFF;
        step();
        expect_obs("tie_result", mk(1, 3'd5, 1, 0, 0, 1, 1, 2'b11, tm(0, 3), tm(0, 3), 1, 0, 0));
        ticks(2);
        expect_obs("result_ignores_tick", mk(1, 3'd5, 1, 0, 0, 1, 1, 2'b11, tm(0, 3), tm(0, 3), 1, 0, 0));
        ack_p2 = 1'b1;
        step();
        expect_obs("tie_one_ack", mk(1, 3'd5, 1, 0, 0, 1, 1, 2'b11, tm(0, 3), tm(0, 3), 1, 0, 0));
        ack_p1 = 1'b1;
        step();
        expect_obs("tie_restart", mk(1, 3'd0, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 1, 0));
        ack_p1 = 1'b0; ack_p2 = 1'b0;
        position_p1 = '0; position_p2 = '0;
        step();
        expect_obs("tie_idle", '0);

        // Watchdog
        start_and_count();
        rx_on = 1'b0;
        ticks(499);
        expect_obs("wd_499", mk(1, 3'd5, 1, 1, 1, 0, 0, 2'b00, tm(0, 499), tm(0, 499), 0, 0, 0));
        tick_1khz = 1'b1;
        step();
        tick_1khz = 1'b0;
        expect_obs("wd_trip", mk(1, 3'd0, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 1, 1));
        step();
        expect_obs("wd_idle_lost", mk(0, 3'd0, 0, 0, 0, 0, 0, 2'b00, '0, '0, 0, 0, 1));
        rx_on = 1'b1;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        expect_obs("rx_clears_lost", '0);

        // Reset mid-race
        start_and_count();
        ticks(300);
        expect_obs("race_ms300", mk(1, 3'd5, 1, 1, 1, 0, 0, 2'b00, tm(0, 300), tm(0, 300), 0, 0, 0));
        step();
        rst = 1'b1;
        expect_obs("rst_mid_race", '0);
        step();
        rst = 1'b0;
        step();
        expect_obs("after_rst_idle", '0);

        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (3) step();
        tests++;
        if (rt_cnt != 3) begin
            fails++;
            $display("FAIL restart_count: got %0d expected 3", rt_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
